// File: rtl/money_input_cond.sv
// rtl/money_input_cond.sv - vending input conditioner: sync, debounce, coin/selection arbitration, card session FSM (option COIN_PEND_EN)
module money_input_cond #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CARD_TIMEOUT    = 255
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic [3:0] coin_raw,
    input  logic [1:0] card_raw,
    input  logic [9:0] sel_raw,
    input  logic       rr_raw,
    output logic       M0,
    output logic       M1,
    output logic       M2,
    output logic       M3,
    output logic       M4,
    output logic       M5,
    output logic       ti,
    output logic       wi,
    output logic       ci,
    output logic       B1,
    output logic       B2,
    output logic       B3,
    output logic       C1,
    output logic       C2,
    output logic       C3,
    output logic       C4,
    output logic       rr,
    output logic       card_err,
    output logic       drop_pulse
);

    localparam int N = 17;
    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0] TO_LAST = 8'(CARD_TIMEOUT - 1);

    typedef enum logic [1:0] {C_IDLE, C_ACTIVE, C_EXPIRED, C_ERROR} card_state_t;

    logic [N-1:0] raw_all, s1, s2, lvl;
    logic [3:0]   db_cnt [N];
    logic [3:0]   coin_d, coin_rise, coin_req, coin_grant;
    logic [9:0]   sel_d, sel_rise, sel_first, sel_grant, slot, slot_n;
    logic         slot_v, slot_v_n, sel_multi, coin_out, coin_drop, sel_drop, rr_db;
    logic [1:0]   card;
    logic [7:0]   idle_cnt;
    card_state_t  state;

    // Bit map: coins [3:0], cards [5:4], selections [15:6], return [16]
    assign raw_all = {rr_raw, sel_raw, card_raw, coin_raw};
    assign rr_db   = lvl[16];
    assign card    = lvl[5:4];
    assign rr      = rr_db;

    always_ff @(posedge CLK) begin
        if (reset) begin
            s1     <= '0;
            s2     <= '0;
            lvl    <= '0;
            coin_d <= '0;
            sel_d  <= '0;
            for (int i = 0; i < N; i++) db_cnt[i] <= '0;
        end else begin
            s1     <= raw_all;
            s2     <= s1;
            coin_d <= lvl[3:0];
            sel_d  <= lvl[15:6];
            for (int i = 0; i < N; i++) begin
                if (s2[i] != lvl[i]) begin
                    if (db_cnt[i] == DB_LAST) begin
                        lvl[i]    <= s2[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 4'd1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign coin_rise = lvl[3:0] & ~coin_d;
    assign sel_rise  = lvl[15:6] & ~sel_d;

`ifdef COIN_PEND_EN
    logic [1:0] pend   [4];
    logic [1:0] pend_n [4];
    logic [3:0] avail;

    always_comb begin
        coin_drop = 1'b0;
        for (int i = 0; i < 4; i++) avail[i] = (pend[i] != 2'd0) || coin_rise[i];
        coin_req   = rr_db ? 4'd0 : avail;
        coin_grant = coin_req & (~coin_req + 4'd1);
        for (int i = 0; i < 4; i++) begin
            if (coin_rise[i] && pend[i] == 2'd3) coin_drop = 1'b1;
            pend_n[i] = pend[i] + {1'b0, coin_rise[i] && pend[i] != 2'd3} - {1'b0, coin_grant[i]};
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < 4; i++) pend[i] <= reset ? 2'd0 : pend_n[i];
    end
`else
    always_comb begin
        coin_req   = rr_db ? 4'd0 : coin_rise;
        coin_grant = coin_req & (~coin_req + 4'd1);
        coin_drop  = (coin_rise & ~coin_grant) != 4'd0;
    end
`endif

    assign coin_out  = coin_grant != 4'd0;
    assign sel_first = sel_rise & (~sel_rise + 10'd1);
    assign sel_multi = (sel_rise & ~sel_first) != 10'd0;

    // A held selection leaves the slot in the same cycle a newcomer may claim it
    always_comb begin
        sel_grant = '0;
        slot_n    = slot;
        slot_v_n  = slot_v;
        sel_drop  = 1'b0;
        if (rr_db) begin
            slot_n   = '0;
            slot_v_n = 1'b0;
            sel_drop = sel_rise != 10'd0;
        end else begin
            sel_drop = sel_multi;
            if (!coin_out && slot_v) begin
                sel_grant = slot;
                slot_v_n  = 1'b0;
            end
            if (sel_rise != 10'd0) begin
                if (!coin_out && !slot_v) begin
                    sel_grant = sel_first;
                end else if (!slot_v_n) begin
                    slot_n   = sel_first;
                    slot_v_n = 1'b1;
                end else begin
                    sel_drop = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            slot   <= '0;
            slot_v <= 1'b0;
            {M3, M2, M1, M0} <= '0;
            {C4, C3, C2, C1, B3, B2, B1, ci, wi, ti} <= '0;
            drop_pulse <= 1'b0;
        end else begin
            slot   <= slot_n;
            slot_v <= slot_v_n;
            {M3, M2, M1, M0} <= coin_grant;
            {C4, C3, C2, C1, B3, B2, B1, ci, wi, ti} <= sel_grant;
            drop_pulse <= coin_drop | sel_drop;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state    <= C_IDLE;
            idle_cnt <= '0;
            M4       <= 1'b0;
            M5       <= 1'b0;
            card_err <= 1'b0;
        end else if (card == 2'b11) begin
            state    <= C_ERROR;
            M4       <= 1'b0;
            M5       <= 1'b0;
            card_err <= 1'b1;
        end else begin
            case (state)
                C_IDLE: if (card != 2'b00) begin
                    state    <= C_ACTIVE;
                    idle_cnt <= '0;
                    M4       <= card[0];
                    M5       <= card[1];
                end
                C_ACTIVE: begin
                    if (card == 2'b00) begin
                        state <= C_IDLE;
                        M4    <= 1'b0;
                        M5    <= 1'b0;
                    end else if (sel_grant != 10'd0) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == TO_LAST) begin
                        state <= C_EXPIRED;
                        M4    <= 1'b0;
                        M5    <= 1'b0;
                    end else begin
                        idle_cnt <= idle_cnt + 8'd1;
                    end
                end
                C_EXPIRED: if (card == 2'b00) state <= C_IDLE;
                default: if (card == 2'b00) begin
                    state    <= C_IDLE;
                    card_err <= 1'b0;
                end
            endcase
        end
    end

endmodule
